// File: rtl/dec_scan_n.sv
`default_nettype none
// ==== dec_scan_n : registered active-low N-to-2^N decoder with 74138 enables and auto-scan | rev 1.0 ====

module dec_scan_n #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  parameter int CNT_W = $clog2(DWELL + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    e1_bar,
  input  logic                    e2_bar,
  input  logic                    e3,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [SEL_W-1:0]        last_idx,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    active,
  output logic                    wrap
);

  localparam int OUTS = 1 << SEL_W;
  localparam logic [OUTS-1:0]  ONE      = {{(OUTS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {OFF, DIRECT, SCAN} state_t;

  state_t            state;
  logic              en;
  logic              mode_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [SEL_W-1:0]  idx_d;
  logic [OUTS-1:0]   out_d;
  logic              active_d;
  logic              wrap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '1;
      idx    <= '0;
      active <= 1'b0;
      wrap   <= 1'b0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      out    <= out_d;
      idx    <= idx_d;
      active <= active_d;
      wrap   <= wrap_d;
      cnt    <= cnt_d;
      mode_q <= mode;
    end
  end

  always_comb begin
    en       = !e1_bar && !e2_bar && e3;
    state    = !en ? OFF : (mode ? SCAN : DIRECT);
    // OFF keeps idx and the dwell count so a paused scan resumes in place
    idx_d    = idx;
    cnt_d    = cnt;
    out_d    = '1;
    active_d = 1'b0;
    wrap_d   = 1'b0;
    case (state)
      DIRECT: begin
        idx_d    = sel;
        cnt_d    = '0;
        out_d    = ~(ONE << sel);
        active_d = 1'b1;
      end
      SCAN: begin
        active_d = 1'b1;
        if (!mode_q) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (cnt == DWELL_M1) begin
          cnt_d = '0;
          // >= also catches last_idx lowered below idx mid-sweep
          if (idx >= last_idx) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx + SEL_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
        out_d = ~(ONE << idx_d);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
